// File: rtl/csr_timer_pkg.sv
// Shared constants and state type for the CSR countdown timer bank.
// Constants only: no latency, no flow control.
package csr_timer_pkg;

  localparam logic [1:0] REG_TCFG  = 2'd0;
  localparam logic [1:0] REG_TVAL  = 2'd1;
  localparam logic [1:0] REG_TICLR = 2'd2;

  localparam int TCFG_EN        = 0;
  localparam int TCFG_PERIOD    = 1;
  localparam int TCFG_INITV_LSB = 2;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_DONE
  } chan_state_e;

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown channel: TCFG register, counter, IDLE/RUN/DONE FSM and pending bit.
// Writes land on the next edge; no backpressure, stall only freezes counting.
module csr_timer_chan
  import csr_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             tcfg_we,
  input  logic             ticlr_we,
  input  logic [CNT_W-1:0] wmask,
  input  logic [CNT_W-1:0] wvalue,
  output logic [CNT_W-1:0] tcfg,
  output logic [CNT_W-1:0] cnt,
  output logic             pending
);

  chan_state_e      state;
  logic [CNT_W-1:0] tcfg_new;
  logic [CNT_W-1:0] reload_new;
  logic [CNT_W-1:0] reload_cur;
  logic             expire;
  logic             clr;

  assign tcfg_new   = (wmask & wvalue) | (~wmask & tcfg);
  assign reload_new = {tcfg_new[CNT_W-1:TCFG_INITV_LSB], 2'b00};
  assign reload_cur = {tcfg[CNT_W-1:TCFG_INITV_LSB], 2'b00};
  assign expire     = !stall && (state == CH_RUN) && (cnt == '0);
  assign clr        = ticlr_we && wmask[0] && wvalue[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg    <= '0;
      cnt     <= '1;
      state   <= CH_IDLE;
      pending <= 1'b0;
    end else begin
      // Expiry is judged on the pre-write state and beats a same-cycle clear.
      if (expire)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;

      if (tcfg_we) begin
        tcfg <= tcfg_new;
        if (tcfg_new[TCFG_EN]) begin
          cnt   <= reload_new;
          state <= CH_RUN;
        end else begin
          state <= CH_IDLE;
        end
      end else if (!stall && state == CH_RUN) begin
        if (cnt != '0)
          cnt <= cnt - CNT_W'(1);
        else if (tcfg[TCFG_PERIOD])
          cnt <= reload_cur;
        else begin
          cnt   <= '1;
          state <= CH_DONE;
        end
      end
    end
  end

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of NUM_TIMERS countdown timers behind a local CSR address space.
// Combinational read mux, writes effective next edge; no backpressure.
module csr_timer_bank
  import csr_timer_pkg::*;
#(
  parameter  int NUM_TIMERS = 4,
  parameter  int CNT_W      = 32,
  localparam int ADDR_W     = $clog2(NUM_TIMERS) + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_we,
  input  logic [ADDR_W-1:0]     csr_addr,
  input  logic [CNT_W-1:0]      csr_wmask,
  input  logic [CNT_W-1:0]      csr_wvalue,
  output logic [CNT_W-1:0]      csr_rvalue,
  input  logic                  stall,
  output logic [NUM_TIMERS-1:0] timer_int,
  output logic                  irq_any
);

  logic [ADDR_W-1:0]     ch_sel;
  logic [1:0]            reg_sel;
  logic [NUM_TIMERS-1:0] tcfg_we;
  logic [NUM_TIMERS-1:0] ticlr_we;
  logic [CNT_W-1:0]      tcfg_q [NUM_TIMERS];
  logic [CNT_W-1:0]      cnt_q  [NUM_TIMERS];

  assign ch_sel  = csr_addr >> 2;
  assign reg_sel = csr_addr[1:0];

  // Channel indices beyond NUM_TIMERS never match, so they read 0 and drop writes.
  always_comb begin
    tcfg_we    = '0;
    ticlr_we   = '0;
    csr_rvalue = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (ch_sel == ADDR_W'(i)) begin
        tcfg_we[i]  = csr_we && (reg_sel == REG_TCFG);
        ticlr_we[i] = csr_we && (reg_sel == REG_TICLR);
        case (reg_sel)
          REG_TCFG: csr_rvalue = tcfg_q[i];
          REG_TVAL: csr_rvalue = cnt_q[i];
          default:  csr_rvalue = '0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    csr_timer_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .tcfg_we (tcfg_we[g]),
      .ticlr_we(ticlr_we[g]),
      .wmask   (csr_wmask),
      .wvalue  (csr_wvalue),
      .tcfg    (tcfg_q[g]),
      .cnt     (cnt_q[g]),
      .pending (timer_int[g])
    );
  end

  assign irq_any = |timer_int;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench for csr_timer_bank: default 4-channel instance plus a 3-channel
// instance for out-of-range channel decode.
module tb_csr_timer_bank;
  import csr_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_we = 1'b0;
  logic        we3 = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  csr_addr = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic [31:0] csr_rvalue;
  logic [31:0] rvalue3;
  logic [3:0]  timer_int;
  logic [2:0]  timer_int3;
  logic        irq_any;
  logic        irq_any3;
  logic        second;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_timer_bank #(.NUM_TIMERS(4), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wmask (csr_wmask),
    .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue),
    .stall     (stall),
    .timer_int (timer_int),
    .irq_any   (irq_any)
  );

  csr_timer_bank #(.NUM_TIMERS(3), .CNT_W(32)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .csr_we    (we3),
    .csr_addr  (csr_addr),
    .csr_wmask (csr_wmask),
    .csr_wvalue(csr_wvalue),
    .csr_rvalue(rvalue3),
    .stall     (stall),
    .timer_int (timer_int3),
    .irq_any   (irq_any3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] a(input int ch, input logic [1:0] r);
    return {2'(ch), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] m, input logic [31:0] v);
    csr_addr = ad; csr_wmask = m; csr_wvalue = v; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic wr3(input logic [3:0] ad, input logic [31:0] m, input logic [31:0] v);
    csr_addr = ad; csr_wmask = m; csr_wvalue = v; we3 = 1'b1;
    tick();
    we3 = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] ad, input logic [31:0] exp);
    csr_addr = ad;
    #1;
    check(tag, csr_rvalue, exp);
  endtask

  task automatic chk_rd3(input string tag, input logic [3:0] ad, input logic [31:0] exp);
    csr_addr = ad;
    #1;
    check(tag, rvalue3, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_int", 32'(timer_int), 32'h0);
    check("rst_any", 32'(irq_any), 32'h0);
    for (int ch = 0; ch < 4; ch++)
      chk_rd("rst_tval", a(ch, REG_TVAL), 32'hFFFF_FFFF);
    chk_rd("rst_tcfg", a(0, REG_TCFG), 32'h0);

    // asynchronous reset mid-count
    wr(a(3, REG_TCFG), 32'hFFFF_FFFF, 32'h1);
    wr(a(0, REG_TCFG), 32'hFFFF_FFFF, 32'h101);
    repeat (3) tick();
    chk_rd("mid_tval", a(0, REG_TVAL), 32'hFD);
    check("mid_int", 32'(timer_int), 32'h8);
    reset = 1'b1;
    #1;
    chk_rd("arst_tval", a(0, REG_TVAL), 32'hFFFF_FFFF);
    chk_rd("arst_tcfg", a(0, REG_TCFG), 32'h0);
    check("arst_int", 32'(timer_int), 32'h0);
    check("arst_any", 32'(irq_any), 32'h0);
    reset = 1'b0;

    // one-shot, INITVAL=2
    wr(a(0, REG_TCFG), 32'hFFFF_FFFF, 32'h9);
    repeat (8) tick();
    chk_rd("os_tval0", a(0, REG_TVAL), 32'h0);
    check("os_pre", 32'(timer_int[0]), 32'h0);
    tick();
    check("os_rise", 32'(timer_int[0]), 32'h1);
    chk_rd("os_tval_done", a(0, REG_TVAL), 32'hFFFF_FFFF);
    wr(a(0, REG_TICLR), 32'h1, 32'h1);
    check("os_clr", 32'(timer_int[0]), 32'h0);
    second = 1'b0;
    repeat (100) begin
      tick();
      if (timer_int[0]) second = 1'b1;
    end
    check("os_no_rearm", 32'(second), 32'h0);

    // periodic, INITVAL=1: period 5
    wr(a(1, REG_TCFG), 32'hFFFF_FFFF, 32'h7);
    repeat (4) tick();
    check("per_low0", 32'(timer_int[1]), 32'h0);
    for (int r = 0; r < 3; r++) begin
      tick();
      check("per_rise", 32'(timer_int[1]), 32'h1);
      wr(a(1, REG_TICLR), 32'h1, 32'h1);
      check("per_clr", 32'(timer_int[1]), 32'h0);
      repeat (3) tick();
      check("per_low", 32'(timer_int[1]), 32'h0);
    end

    // periodic, INITVAL=0: set every cycle beats a TICLR every cycle
    wr(a(1, REG_TCFG), 32'hFFFF_FFFF, 32'h3);
    csr_addr = a(1, REG_TICLR); csr_wmask = 32'h1; csr_wvalue = 32'h1; csr_we = 1'b1;
    repeat (6) begin
      tick();
      check("per0_hold", 32'(timer_int[1]), 32'h1);
    end
    csr_we = 1'b0;
    wr(a(1, REG_TCFG), 32'h1, 32'h0);
    wr(a(1, REG_TICLR), 32'h1, 32'h1);
    check("per0_off", 32'(timer_int[1]), 32'h0);

    // stall freezes the counter
    wr(a(2, REG_TCFG), 32'hFFFF_FFFF, 32'h101);
    repeat (2) tick();
    chk_rd("stl_pre", a(2, REG_TVAL), 32'hFE);
    stall = 1'b1;
    repeat (10) tick();
    chk_rd("stl_hold", a(2, REG_TVAL), 32'hFE);
    stall = 1'b0;
    tick();
    chk_rd("stl_go", a(2, REG_TVAL), 32'hFD);

    // masked write clears only EN; counter holds in IDLE
    wr(a(2, REG_TCFG), 32'h1, 32'h0);
    chk_rd("msk_tcfg", a(2, REG_TCFG), 32'h100);
    repeat (3) tick();
    chk_rd("msk_tval", a(2, REG_TVAL), 32'hFD);

    // TICLR coincident with expiry
    wr(a(3, REG_TCFG), 32'hFFFF_FFFF, 32'h5);
    repeat (4) tick();
    check("col_pre", 32'(timer_int[3]), 32'h0);
    wr(a(3, REG_TICLR), 32'h1, 32'h1);
    check("col_ticlr", 32'(timer_int[3]), 32'h1);

    // TCFG rewrite coincident with expiry
    wr(a(0, REG_TCFG), 32'hFFFF_FFFF, 32'h5);
    repeat (4) tick();
    check("col2_pre", 32'(timer_int[0]), 32'h0);
    wr(a(0, REG_TCFG), 32'hFFFF_FFFF, 32'hD);
    check("col2_int", 32'(timer_int[0]), 32'h1);
    chk_rd("col2_tval", a(0, REG_TVAL), 32'hC);
    tick();
    chk_rd("col2_dec", a(0, REG_TVAL), 32'hB);
    check("col2_any", 32'(irq_any), 32'h1);
    chk_rd("ticlr_rd", a(0, REG_TICLR), 32'h0);
    chk_rd("rsv_rd", a(0, 2'd3), 32'h0);

    // 3-channel instance: index 3 is out of range
    wr3(a(3, REG_TCFG), 32'hFFFF_FFFF, 32'h9);
    repeat (12) tick();
    chk_rd3("oob_tcfg", a(3, REG_TCFG), 32'h0);
    chk_rd3("oob_tval", a(3, REG_TVAL), 32'h0);
    check("oob_int", 32'(timer_int3), 32'h0);
    chk_rd3("oob_ch2_tval", a(2, REG_TVAL), 32'hFFFF_FFFF);
    chk_rd3("oob_ch2_tcfg", a(2, REG_TCFG), 32'h0);
    wr3(a(2, REG_TCFG), 32'hFFFF_FFFF, 32'h5);
    repeat (4) tick();
    check("n3_pre", 32'(timer_int3), 32'h0);
    tick();
    check("n3_ch2", 32'(timer_int3), 32'h4);
    check("n3_any", 32'(irq_any3), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
